// File: rtl/lighthouse_emulator.sv
// Lighthouse base-station emulator: an Avalon-MM register block that generates the sync/sweep photodiode waveform.
// Optional feature macro LH_EMU_OOTX_EN: register 6 holds an OOTX word whose bits, MSB first, become the per-frame data bit.
module lighthouse_emulator #(
  parameter int unsigned SYNC_BASE = 3000,
  parameter int unsigned SYNC_STEP = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        sensor_signal_o
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_GAP, S_SWEEP, S_TAIL} state_t;

  typedef struct packed {
    logic skip;
    logic axis;
    logic data;
    logic auto_axis;
    logic enable;
  } ctrl_t;

  state_t      state;
  ctrl_t       ctrl_q, sh_ctrl;
  logic [31:0] sweep_delay, sweep_width, period, frame_count;
  logic [31:0] sh_delay, sh_width, sh_period;
  logic [31:0] timer, seg_cnt;
  logic [2:0]  code;
  logic [31:0] sync_w;
  logic        tail_done, go_sync, ctrl_wr, next_axis, next_data;
  logic        unused_read;

`ifdef LH_EMU_OOTX_EN
  logic [31:0] ootx_word, ootx_sr, fc_entry;
  logic        load_ootx;
`endif

  // Avalon reads have no side effects, so the strobe carries no information here.
  assign unused_read = read;
  assign waitrequest = 1'b0;

  always_comb begin
    code      = {sh_ctrl.skip, sh_ctrl.data, sh_ctrl.axis};
    sync_w    = SYNC_BASE + SYNC_STEP * {29'd0, code};
    tail_done = (state == S_TAIL) && (({1'b0, timer} + 33'd1) >= {1'b0, sh_period});
    go_sync   = ((state == S_IDLE) || tail_done) && ctrl_q.enable;
    ctrl_wr   = write && (address == 3'd0);
    next_axis = (tail_done && sh_ctrl.auto_axis) ? ~ctrl_q.axis : ctrl_q.axis;
`ifdef LH_EMU_OOTX_EN
    fc_entry  = tail_done ? frame_count + 32'd1 : frame_count;
    load_ootx = (fc_entry[4:0] == 5'd0);
    next_data = load_ootx ? ootx_word[31] : ootx_sr[31];
`else
    next_data = ctrl_q.data;
`endif
  end

  // NOTE: readdata gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    readdata = 32'hDEAD_BEEF;
    case (address)
      3'd0:    readdata = {27'd0, ctrl_q};
      3'd1:    readdata = sweep_delay;
      3'd2:    readdata = sweep_width;
      3'd3:    readdata = period;
      3'd4:    readdata = frame_count;
      3'd5:    readdata = {27'd0, code, sh_ctrl.axis, state != S_IDLE};
`ifdef LH_EMU_OOTX_EN
      3'd6:    readdata = ootx_word;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      sensor_signal_o <= 1'b0;
      ctrl_q          <= '0;
      sh_ctrl         <= '0;
      sweep_delay     <= '0;
      sweep_width     <= '0;
      period          <= '0;
      frame_count     <= '0;
      sh_delay        <= '0;
      sh_width        <= '0;
      sh_period       <= '0;
      timer           <= '0;
      seg_cnt         <= '0;
`ifdef LH_EMU_OOTX_EN
      ootx_word       <= '0;
      ootx_sr         <= '0;
`endif
    end else begin
      // The pin follows the registered state, so it lags every state change by one clock.
      sensor_signal_o <= (state == S_SYNC) || (state == S_SWEEP);
      if (state != S_IDLE) begin
        timer   <= timer + 32'd1;
        seg_cnt <= seg_cnt + 32'd1;
      end

      if (write) begin
        case (address)
          3'd0:    ctrl_q      <= ctrl_t'(writedata[4:0]);
          3'd1:    sweep_delay <= writedata;
          3'd2:    sweep_width <= writedata;
          3'd3:    period      <= writedata;
`ifdef LH_EMU_OOTX_EN
          3'd6:    ootx_word   <= writedata;
`endif
          default: ;
        endcase
      end

      case (state)
        S_SYNC: if (seg_cnt == sync_w - 32'd1) begin
          state   <= S_GAP;
          seg_cnt <= '0;
        end
        S_GAP: if (({1'b0, timer} + 33'd1) >= {1'b0, sh_delay}) begin
          state   <= (sh_ctrl.skip || (sh_width == 32'd0)) ? S_TAIL : S_SWEEP;
          seg_cnt <= '0;
        end
        S_SWEEP: if (seg_cnt == sh_width - 32'd1) begin
          state   <= S_TAIL;
          seg_cnt <= '0;
        end
        default: ;
      endcase

      if (tail_done) begin
        frame_count <= frame_count + 32'd1;
        // A CTRL write landing on the same edge wins over the automatic toggle.
        if (sh_ctrl.auto_axis && !ctrl_wr) ctrl_q.axis <= ~ctrl_q.axis;
        state <= S_IDLE;
      end

      // Frame start: freeze the configuration so mid-frame writes only affect the next frame.
      if (go_sync) begin
        state     <= S_SYNC;
        timer     <= '0;
        seg_cnt   <= '0;
        sh_ctrl   <= {ctrl_q.skip, next_axis, next_data, ctrl_q.auto_axis, ctrl_q.enable};
        sh_delay  <= sweep_delay;
        sh_width  <= sweep_width;
        sh_period <= period;
`ifdef LH_EMU_OOTX_EN
        ootx_sr   <= load_ootx ? {ootx_word[30:0], 1'b0} : {ootx_sr[30:0], 1'b0};
`endif
      end
    end
  end

endmodule

// File: tb/tb_lighthouse_emulator.sv
// Bench for lighthouse_emulator: a negedge monitor records sensor pulses, each test queues the pulses it expects.
`timescale 1ns/1ps
module tb_lighthouse_emulator;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        sensor_signal_o;

  always #5 clock = ~clock;

  lighthouse_emulator dut (
    .clock           (clock),
    .reset           (reset),
    .address         (address),
    .write           (write),
    .writedata       (writedata),
    .read            (read),
    .readdata        (readdata),
    .waitrequest     (waitrequest),
    .sensor_signal_o (sensor_signal_o)
  );

  typedef struct {
    int unsigned rise;
    int unsigned width;
  } pulse_t;

  pulse_t      exp_q[$];
  pulse_t      obs_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;
  int unsigned rise_cyc    = 0;
  logic        prev_s      = 1'b0;
  logic [31:0] fc_model    = 32'd0;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor: rise cycle and width of every high pulse on the sensor pin.
  always @(negedge clock) begin
    if (sensor_signal_o === 1'b1 && prev_s !== 1'b1) rise_cyc = cyc;
    if (sensor_signal_o !== 1'b1 && prev_s === 1'b1) obs_q.push_back('{rise_cyc, cyc - rise_cyc});
    prev_s = sensor_signal_o;
  end

  function automatic void expect_pulse(input int unsigned offset, input int unsigned width);
    exp_q.push_back('{offset, width});
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clock);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clock);
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clock);
    address = a;
    read    = 1'b1;
    #1 d    = readdata;
    read    = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    vectors++;
    if (obs_q.size() < n) begin
      miscompares++;
      $display("FAIL %s: saw %0d pulses after %0d cycles, expected %0d", name, obs_q.size(), budget, n);
    end
  endtask

  task automatic wait_sensor_high(input int budget, input string name);
    int k = 0;
    while (sensor_signal_o !== 1'b1 && k < budget) begin
      @(negedge clock);
      k++;
    end
    vectors++;
    if (sensor_signal_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: sensor is %b after %0d cycles, expected 1", name, sensor_signal_o, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic [31:0] d;
    int k = 0;
    bus_read(3'd5, d);
    while (d[0] !== 1'b0 && k < budget) begin
      bus_read(3'd5, d);
      k++;
    end
    vectors++;
    if (d[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: busy is %b after %0d cycles, expected 0", name, d[0], budget);
    end
  endtask

  // Scoreboard drain: offsets are relative to the first observed pulse of the scenario.
  task automatic compare_pulses(input string name);
    pulse_t      e, o;
    int unsigned base = 0;
    bit          have_base = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s: pulse missing, expected offset %0d width %0d", name, e.rise, e.width);
      end else begin
        o = obs_q.pop_front();
        if (!have_base) begin
          base      = o.rise;
          have_base = 1'b1;
        end
        if ((o.rise - base) !== e.rise || o.width !== e.width) begin
          miscompares++;
          $display("FAIL %s: pulse offset %0d width %0d, expected offset %0d width %0d",
                   name, o.rise - base, o.width, e.rise, e.width);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d extra pulses, expected 0", name, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic check_frame_count(input string name);
    logic [31:0] d;
    bus_read(3'd4, d);
    vectors++;
    if (d !== fc_model) begin
      miscompares++;
      $display("FAIL %s: FRAME_COUNT %0d, expected %0d", name, d, fc_model);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_reg [8];
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) exp_reg[a] = 32'd0;
`ifndef LH_EMU_OOTX_EN
    exp_reg[6] = 32'hDEAD_BEEF;
`endif
    exp_reg[7] = 32'hDEAD_BEEF;
    for (int a = 0; a < 8; a++) begin
      bus_read(a[2:0], d);
      vectors++;
      if (d !== exp_reg[a]) begin
        miscompares++;
        $display("FAIL reset_reg%0d: read %h, expected %h", a, d, exp_reg[a]);
      end
    end
    vectors++;
    if (sensor_signal_o !== 1'b0 || waitrequest !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pins: sensor %b waitrequest %b, expected 0 0", sensor_signal_o, waitrequest);
    end
  endtask

  task automatic test_frame();
    logic [31:0] d;
    bus_write(3'd1, 32'd4000);
    bus_write(3'd2, 32'd200);
    bus_write(3'd3, 32'd5000);
    bus_write(3'd0, 32'h09);
    expect_pulse(0, 3500);
    expect_pulse(4000, 200);
    expect_pulse(5000, 3500);
    expect_pulse(9000, 200);
    wait_pulses(1, 4000, "frame_sync");
    bus_read(3'd5, d);
    vectors++;
    if (d !== 32'd7) begin
      miscompares++;
      $display("FAIL frame_status: read %h, expected %h", d, 32'd7);
    end
    wait_pulses(3, 8000, "frame_second");
    bus_write(3'd0, 32'h08);
    wait_idle(3000, "frame_idle");
    compare_pulses("frame");
    fc_model += 2;
    check_frame_count("frame_count");
  endtask

  task automatic test_skip();
    logic [31:0] d;
    bus_write(3'd3, 32'd6000);
    bus_write(3'd0, 32'h11);
    expect_pulse(0, 5000);
    expect_pulse(6000, 5000);
    wait_pulses(1, 6000, "skip_sync");
    bus_read(3'd5, d);
    vectors++;
    if (d !== 32'd17) begin
      miscompares++;
      $display("FAIL skip_status: read %h, expected %h", d, 32'd17);
    end
    wait_pulses(2, 8000, "skip_second");
    bus_write(3'd0, 32'h10);
    wait_idle(3000, "skip_idle");
    compare_pulses("skip");
    fc_model += 2;
    check_frame_count("skip_count");
  endtask

  task automatic test_auto_axis();
    logic [31:0] d;
    logic [31:0] exp_status;
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'd0);
    bus_write(3'd3, 32'd4000);
    bus_write(3'd0, 32'h03);
    for (int k = 0; k < 4; k++) expect_pulse(k * 4000, (k % 2 == 1) ? 3500 : 3000);
    for (int k = 0; k < 4; k++) begin
      wait_pulses(k + 1, 5000, "auto_wait");
      bus_read(3'd5, d);
      exp_status = (k % 2 == 1) ? 32'd7 : 32'd1;
      vectors++;
      if (d !== exp_status) begin
        miscompares++;
        $display("FAIL auto_status%0d: read %h, expected %h", k, d, exp_status);
      end
    end
    bus_write(3'd0, 32'h02);
    wait_idle(2000, "auto_idle");
    compare_pulses("auto_axis");
    fc_model += 4;
    check_frame_count("auto_count");
  endtask

  task automatic test_short_delay();
    bus_write(3'd1, 32'd100);
    bus_write(3'd2, 32'd20);
    bus_write(3'd3, 32'd3500);
    bus_write(3'd0, 32'h01);
    expect_pulse(0, 3000);
    expect_pulse(3001, 20);
    wait_pulses(1, 4000, "short_sync");
    bus_write(3'd0, 32'h00);
    wait_idle(2000, "short_idle");
    compare_pulses("short_delay");
    fc_model += 1;
    check_frame_count("short_count");
  endtask

  task automatic test_midframe_write();
    logic [31:0] d;
    bus_write(3'd1, 32'd3100);
    bus_write(3'd2, 32'd300);
    bus_write(3'd3, 32'd4000);
    bus_write(3'd0, 32'h01);
    expect_pulse(0, 3000);
    expect_pulse(3100, 300);
    wait_pulses(1, 4000, "mid_sync");
    wait_sensor_high(300, "mid_sweep_start");
    bus_write(3'd2, 32'd50);
    bus_write(3'd0, 32'h00);
    bus_read(3'd2, d);
    vectors++;
    if (d !== 32'd50) begin
      miscompares++;
      $display("FAIL mid_width_reg: read %0d, expected %0d", d, 50);
    end
    wait_pulses(2, 1000, "mid_sweep_end");
    bus_read(3'd5, d);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("FAIL mid_tail_busy: read %h, expected %h", d, 32'd1);
    end
    wait_idle(2000, "mid_idle");
    repeat (6000) @(negedge clock);
    compare_pulses("midframe");
    fc_model += 1;
    check_frame_count("mid_count");
  endtask

  task automatic test_reset_mid_sync();
    logic [31:0] d;
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'd0);
    bus_write(3'd3, 32'd4000);
    bus_write(3'd0, 32'h01);
    wait_sensor_high(50, "rst_sync_start");
    repeat (100) @(negedge clock);
    check_frame_count("rst_count_before");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    vectors++;
    if (sensor_signal_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_sensor: sensor %b, expected 0", sensor_signal_o);
    end
    fc_model = 32'd0;
    check_frame_count("rst_count_after");
    bus_read(3'd7, d);
    vectors++;
    if (d !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rst_addr7: read %h, expected %h", d, 32'hDEAD_BEEF);
    end
    bus_read(3'd5, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_status: read %h, expected %h", d, 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    vectors++;
    if (sensor_signal_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_quiet: sensor %b, expected 0", sensor_signal_o);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    write     = 1'b0;
    read      = 1'b0;
    address   = 3'd0;
    writedata = 32'd0;
    test_reset();
    test_frame();
    test_skip();
    test_auto_axis();
    test_short_delay();
    test_midframe_write();
    test_reset_mid_sync();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lighthouse_emulator.md
LIGHTHOUSE_EMULATOR -- requirements
Module: lighthouse_emulator

Interface
REQ-001 SHALL have parameter SYNC_BASE, default 3000, sync pulse width in clocks for code 0.
REQ-002 SHALL have parameter SYNC_STEP, default 500, extra sync width in clocks per code increment.
REQ-003 SHALL have port clock  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address  input  3  Avalon slave register index.
REQ-006 SHALL have port write  input  1  Avalon write strobe.
REQ-007 SHALL have port writedata  input  32  Avalon write data.
REQ-008 SHALL have port read  input  1  Avalon read strobe.
REQ-009 SHALL have port readdata  output  32  Avalon read data.
REQ-010 SHALL have port waitrequest  output  1  Avalon stall, tied 0.
REQ-011 SHALL have port sensor_signal_o  output  1  emulated photodiode output, feeds a lighthouse sensor decoder input.

Function
REQ-012 SHALL decode registers: 0 CTRL {bit0 enable, bit1 auto_axis, bit2 data, bit3 axis, bit4 skip}; 1 SWEEP_DELAY; 2 SWEEP_WIDTH; 3 PERIOD; 4 FRAME_COUNT (read-only); 5 STATUS {bit0 busy, bit1 current axis, bits4:2 current code}; other addresses read 32'hDEAD_BEEF.
REQ-013 SHALL return readdata combinationally from address (zero read latency); writes take effect on the clock edge where write is high.
REQ-014 SHALL latch CTRL, SWEEP_DELAY, SWEEP_WIDTH and PERIOD into shadow registers only on entry to SYNC; mid-frame register writes affect the next frame only.
REQ-015 SHALL form code = {skip, data, axis} (3 bits) and sync width = SYNC_BASE + SYNC_STEP*code clocks, computed in 32 bits.
REQ-016 SHALL implement FSM IDLE -> SYNC -> GAP -> SWEEP -> TAIL -> SYNC/IDLE, with a 32-bit frame timer cleared on SYNC entry.
REQ-017 IDLE: output 0; move to SYNC when enable=1.
REQ-018 SYNC: output 1 for exactly sync-width clocks, then GAP.
REQ-019 GAP: output 0 until timer equals SWEEP_DELAY, then SWEEP; if SWEEP_DELAY <= sync width, GAP lasts exactly one clock.
REQ-020 SWEEP: output 1 for SWEEP_WIDTH clocks, then TAIL; skip=1 or SWEEP_WIDTH=0 bypasses SWEEP (output stays 0).
REQ-021 TAIL: output 0 until timer equals PERIOD-1, minimum one clock; then increment FRAME_COUNT (wraps 2^32-1 -> 0), toggle axis if auto_axis=1, and go to SYNC if enable=1, else IDLE.
REQ-022 Clearing enable mid-frame SHALL complete the current frame; no truncated pulses.
REQ-023 sensor_signal_o SHALL be registered (glitch-free), one clock after the state change.
REQ-024 STATUS.busy SHALL be 1 in every state except IDLE.

Reset
REQ-025 On reset: state IDLE, sensor_signal_o 0, CTRL 0, SWEEP_DELAY 0, SWEEP_WIDTH 0, PERIOD 0, FRAME_COUNT 0, shadows 0, timer 0.
REQ-026 Reset asserted mid-pulse SHALL drive sensor_signal_o to 0 on the next clock edge.

Configuration
REQ-027 With LH_EMU_OOTX_EN defined: register 6 is a writable 32-bit OOTX word, the data bit of each frame is taken MSB-first from a shift register loaded from it when FRAME_COUNT[4:0]==0 and shifted once per frame, and CTRL.bit2 is ignored.
REQ-028 Without LH_EMU_OOTX_EN: the data bit is CTRL.bit2, and register 6 reads 32'hDEAD_BEEF and ignores writes.

Verification
REQ-029 CTRL=0x09 (enable, axis=1), SWEEP_DELAY=10000, SWEEP_WIDTH=200, PERIOD=400000 -> sync high 3500 clocks, rise at t=10000 for 200 clocks, next sync rise at t=400000.
REQ-030 CTRL=0x11 (enable, skip=1) -> sync width 5000, no sweep pulse, FRAME_COUNT increments by 1 per 400000 clocks.
REQ-031 CTRL=0x03 (auto_axis) over 4 frames -> sync widths 3000, 3500, 3000, 3500; STATUS bit1 alternates.
REQ-032 SWEEP_DELAY=100 with sync width 3000 -> sweep rises exactly one clock after sync falls.
REQ-033 Write SWEEP_WIDTH=50 mid-sweep, then clear enable -> current sweep keeps the old width, the next frame does not start, and STATUS.busy falls after TAIL.
REQ-034 Reset asserted during SYNC -> sensor_signal_o=0 next clock, readdata at address 4 = 0, address 7 = 32'hDEAD_BEEF.
